// File: rtl/sensor_conditioner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sensor_conditioner_if : raw sensor inputs and conditioned outputs bundle.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sensor_conditioner_if;
    logic       F_raw;
    logic       T_raw;
    logic       LE_raw;
    logic       LD_raw;
    logic       bateria_raw;
    logic       botao_raw;
    logic       F;
    logic       T;
    logic       LE;
    logic       LD;
    logic       bateria;
    logic       botao;
    logic       press_pulse;
    logic [3:0] stuck;

    modport slave (
        input  F_raw, T_raw, LE_raw, LD_raw, bateria_raw, botao_raw,
        output F, T, LE, LD, bateria, botao, press_pulse, stuck
    );

    modport master (
        output F_raw, T_raw, LE_raw, LD_raw, bateria_raw, botao_raw,
        input  F, T, LE, LD, bateria, botao, press_pulse, stuck
    );
endinterface
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sensor_conditioner : sync + debounce of bump/battery/button inputs, power  |
// | FSM, optional stuck-sensor detection (macro SENSOR_STUCK_DET_EN). Rev 1.0  |
// +----------------------------------------------------------------------------+
module sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STUCK_CYCLES    = 1024
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    sensor_conditioner_if.slave bus
);

    localparam int              c_NCH     = 6;
    localparam int              c_IDX_BAT = 4;
    localparam int              c_IDX_BTN = 5;
    localparam int              c_CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_ST_OFF    = 2'd0;
    localparam logic [1:0] c_ST_ON     = 2'd1;
    localparam logic [1:0] c_ST_LOWBAT = 2'd2;

    generate
        if ((DEBOUNCE_CYCLES < 2) || (STUCK_CYCLES < 1)) begin : g_param_check
            $error("sensor_conditioner: DEBOUNCE_CYCLES must be >= 2 and STUCK_CYCLES >= 1");
        end
    endgenerate

    logic [c_NCH-1:0] w_raw;
    logic [c_NCH-1:0] w_level;

    assign w_raw = {bus.botao_raw, bus.bateria_raw, bus.LD_raw,
                    bus.LE_raw,    bus.T_raw,       bus.F_raw};

    // Each channel: 2-FF synchroniser, then a level accepted only after
    // DEBOUNCE_CYCLES consecutive synced samples disagree with it.
    generate
        for (genvar gi = 0; gi < c_NCH; gi++) begin : g_chan
            logic            sync1_q;
            logic            sync2_q;
            logic            level_q;
            logic            level_d;
            logic [c_CW-1:0] cnt_q;
            logic [c_CW-1:0] cnt_d;

            always_comb begin
                level_d = level_q;
                cnt_d   = cnt_q;
                if (sync2_q == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == c_CNT_MAX) begin
                    level_d = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= w_raw[gi];
                    sync2_q <= sync1_q;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign w_level[gi] = level_q;
        end
    endgenerate

    logic btn_prev_q;
    logic press_pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q    <= 1'b0;
            press_pulse_q <= 1'b0;
        end else begin
            btn_prev_q    <= w_level[c_IDX_BTN];
            press_pulse_q <= w_level[c_IDX_BTN] & ~btn_prev_q;
        end
    end

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       botao_q;
    logic       botao_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_OFF;
            botao_q <= 1'b0;
        end else begin
            state_q <= state_d;
            botao_q <= botao_d;
        end
    end

    // Battery loss in ON wins over a simultaneous press.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_OFF: begin
                if (press_pulse_q && w_level[c_IDX_BAT]) begin
                    state_d = c_ST_ON;
                end
            end
            c_ST_ON: begin
                if (!w_level[c_IDX_BAT]) begin
                    state_d = c_ST_LOWBAT;
                end else if (press_pulse_q) begin
                    state_d = c_ST_OFF;
                end
            end
            c_ST_LOWBAT: begin
                if (w_level[c_IDX_BAT]) begin
                    state_d = c_ST_OFF;
                end
            end
            default: state_d = c_ST_OFF;
        endcase
    end

    always_comb begin
        botao_d = (state_d == c_ST_ON);
    end

    assign bus.F           = w_level[0];
    assign bus.T           = w_level[1];
    assign bus.LE          = w_level[2];
    assign bus.LD          = w_level[3];
    assign bus.bateria     = w_level[c_IDX_BAT];
    assign bus.botao       = botao_q;
    assign bus.press_pulse = press_pulse_q;

`ifdef SENSOR_STUCK_DET_EN
    localparam int              c_SW        = $clog2(STUCK_CYCLES + 1);
    localparam logic [c_SW-1:0] c_STUCK_MAX = c_SW'(STUCK_CYCLES);
    localparam logic [c_SW-1:0] c_STUCK_HIT = c_SW'(STUCK_CYCLES - 1);

    logic       w_enter_off;
    logic [3:0] w_stuck;

    assign w_enter_off = (state_d == c_ST_OFF) && (state_q != c_ST_OFF);

    // Flag sets only on the cycle the count reaches the limit, so a flag
    // cleared by power-off stays clear while the sensor remains pressed.
    generate
        for (genvar gs = 0; gs < 4; gs++) begin : g_stuck
            logic [c_SW-1:0] run_q;
            logic            flag_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    run_q <= '0;
                end else if (!w_level[gs]) begin
                    run_q <= '0;
                end else if (run_q != c_STUCK_MAX) begin
                    run_q <= run_q + c_SW'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    flag_q <= 1'b0;
                end else if (w_enter_off) begin
                    flag_q <= 1'b0;
                end else if (w_level[gs] && (run_q == c_STUCK_HIT)) begin
                    flag_q <= 1'b1;
                end
            end

            assign w_stuck[3-gs] = flag_q;
        end
    endgenerate

    assign bus.stuck = w_stuck;
`else
    assign bus.stuck = 4'b0000;
`endif

endmodule
`default_nettype wire
